// File: rtl/deadtime_inserter.sv
// Three-phase dead-time inserter: turns each SPWM comparator bit into a
// complementary high/low gate pair separated by DEAD_CYCLES clocks with both off.
//
// state | meaning
// ------+-----------------------------------------------------------
// OFF   | gates disabled, both switches off
// DEAD  | both switches off, counting down the dead period
// HI    | high-side switch conducting
// LO    | low-side switch conducting
module deadtime_inserter #(
   parameter int DEAD_CYCLES = 50,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic pwm_a,
   input  logic pwm_b,
   input  logic pwm_c,
   output logic ha,
   output logic la,
   output logic hb,
   output logic lb,
   output logic hc,
   output logic lc
);

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      DEAD = 2'd1,
      HI   = 2'd2,
      LO   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYCLES - 1);

   logic [2:0] pwm_raw;
   logic [2:0] h_gate;
   logic [2:0] l_gate;

   assign pwm_raw = {pwm_c, pwm_b, pwm_a};

   for (genvar g = 0; g < 3; g++) begin : g_phase
      state_t           state;
      state_t           state_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             pwm_q;
      logic             h_q;
      logic             l_q;

      // Gate flops follow the next state so a turn-off lands on the same edge
      // that the FSM leaves HI/LO, keeping the off window exactly DEAD_CYCLES.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= OFF;
            cnt   <= '0;
            pwm_q <= 1'b0;
            h_q   <= 1'b0;
            l_q   <= 1'b0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pwm_q <= pwm_raw[g];
            h_q   <= (state_nxt == HI);
            l_q   <= (state_nxt == LO);
         end
      end

      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         if (!en) begin
            state_nxt = OFF;
         end else begin
            case (state)
               OFF: begin
                  state_nxt = DEAD;
                  cnt_nxt   = CNT_LOAD;
               end
               HI: begin
                  if (!pwm_q) begin
                     state_nxt = DEAD;
                     cnt_nxt   = CNT_LOAD;
                  end
               end
               LO: begin
                  if (pwm_q) begin
                     state_nxt = DEAD;
                     cnt_nxt   = CNT_LOAD;
                  end
               end
               DEAD: begin
                  // Inputs seen during the dead period are ignored; only the
                  // request present at expiry decides which side turns on.
                  if (cnt == '0) begin
                     state_nxt = pwm_q ? HI : LO;
                  end else begin
                     cnt_nxt = cnt - 1'b1;
                  end
               end
               default: state_nxt = OFF;
            endcase
         end
      end

      assign h_gate[g] = h_q;
      assign l_gate[g] = l_q;
   end

   assign ha = h_gate[0];
   assign la = l_gate[0];
   assign hb = h_gate[1];
   assign lb = l_gate[1];
   assign hc = h_gate[2];
   assign lc = l_gate[2];

endmodule

// File: tb/tb_deadtime_inserter.sv
// Directed bench for deadtime_inserter with DEAD_CYCLES=4, plus gate-invariant
// monitors that stay active through a short randomized tail.
module tb_deadtime_inserter;

   localparam int DEAD = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic en;
   logic pwm_a, pwm_b, pwm_c;
   logic ha, la, hb, lb, hc, lc;
   logic [5:0] outs;

   int n_checks = 0;
   int n_fail   = 0;

   int  off_cnt [3] = '{0, 0, 0};
   logic [2:0] prev_h = '0;
   logic [2:0] prev_l = '0;
   logic done = 1'b0;

   always #5 clk = ~clk;

   deadtime_inserter #(.DEAD_CYCLES(DEAD), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .pwm_a (pwm_a),
      .pwm_b (pwm_b),
      .pwm_c (pwm_c),
      .ha    (ha),
      .la    (la),
      .hb    (hb),
      .lb    (lb),
      .hc    (hc),
      .lc    (lc)
   );

   assign outs = {ha, la, hb, lb, hc, lc};

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step_chk(input string tag, input logic [5:0] exp);
      @(posedge clk);
      #1;
      chk(tag, outs, exp);
   endtask

   // Independent invariant checks sampled on the falling edge.
   always @(negedge clk) begin
      if (!done) begin
         logic [2:0] h_now, l_now;
         h_now = {hc, hb, ha};
         l_now = {lc, lb, la};
         for (int p = 0; p < 3; p++) begin
            n_checks++;
            assert ((h_now[p] & l_now[p]) === 1'b0)
            else begin
               n_fail++;
               $error("FAIL overlap phase%0d observed h=%b l=%b expected not both 1",
                      p, h_now[p], l_now[p]);
            end
            if ((h_now[p] & !prev_h[p]) | (l_now[p] & !prev_l[p])) begin
               n_checks++;
               assert (off_cnt[p] >= DEAD)
               else begin
                  n_fail++;
                  $error("FAIL deadgap phase%0d observed off_cycles=%0d expected >=%0d",
                         p, off_cnt[p], DEAD);
               end
            end
            if (h_now[p] | l_now[p]) off_cnt[p] = 0;
            else if (off_cnt[p] < 1000) off_cnt[p] = off_cnt[p] + 1;
         end
         prev_h = h_now;
         prev_l = l_now;
      end
   end

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      pwm_a = 1'b1;
      pwm_b = 1'b0;
      pwm_c = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hold", outs, 6'b00_00_00);

      // 1: release reset, full dead period then per-phase side turns on
      rst_n = 1'b1;
      for (int i = 0; i < DEAD; i++) step_chk("t1_dead", 6'b00_00_00);
      step_chk("t1_on", 6'b10_01_10);

      // A: HI -> LO
      pwm_a = 1'b0;
      step_chk("hl_edge_k", 6'b10_01_10);
      for (int i = 0; i < DEAD; i++) step_chk("hl_dead", 6'b00_01_10);
      step_chk("hl_on", 6'b01_01_10);

      // 2: A: LO -> HI
      pwm_a = 1'b1;
      step_chk("t2_edge_k", 6'b01_01_10);
      for (int i = 0; i < DEAD; i++) step_chk("t2_dead", 6'b00_01_10);
      step_chk("t2_on", 6'b10_01_10);

      // back to LO, then a 2-cycle pulse that dies during DEAD
      pwm_a = 1'b0;
      step_chk("t3_pre_k", 6'b10_01_10);
      for (int i = 0; i < DEAD; i++) step_chk("t3_pre_dead", 6'b00_01_10);
      step_chk("t3_pre_on", 6'b01_01_10);
      pwm_a = 1'b1;
      step_chk("t3_edge_k", 6'b01_01_10);
      step_chk("t3_dead0", 6'b00_01_10);
      pwm_a = 1'b0;
      for (int i = 1; i < DEAD; i++) step_chk("t3_dead", 6'b00_01_10);
      step_chk("t3_back_lo", 6'b01_01_10);

      // phase B transitions alone; A and C unaffected
      pwm_b = 1'b1;
      step_chk("b_edge_k", 6'b01_01_10);
      for (int i = 0; i < DEAD; i++) step_chk("b_dead", 6'b01_00_10);
      step_chk("b_on", 6'b01_10_10);

      // 4: A to HI, then disable / re-enable
      pwm_a = 1'b1;
      step_chk("t4_edge_k", 6'b01_10_10);
      for (int i = 0; i < DEAD; i++) step_chk("t4_dead", 6'b00_10_10);
      step_chk("t4_hi", 6'b10_10_10);
      en = 1'b0;
      step_chk("t4_en_off", 6'b00_00_00);
      step_chk("t4_en_off2", 6'b00_00_00);
      pwm_a = 1'b0;
      en = 1'b1;
      for (int i = 0; i < DEAD; i++) step_chk("t4_reen_dead", 6'b00_00_00);
      step_chk("t4_reen_on", 6'b01_10_10);

      // reset asserted mid-DEAD clears all gates without a clock edge
      pwm_a = 1'b1;
      step_chk("t4r_edge_k", 6'b01_10_10);
      step_chk("t4r_dead0", 6'b00_10_10);
      step_chk("t4r_dead1", 6'b00_10_10);
      rst_n = 1'b0;
      #1;
      chk("t4r_async_clr", outs, 6'b00_00_00);
      step_chk("t4r_in_reset", 6'b00_00_00);
      rst_n = 1'b1;
      for (int i = 0; i < DEAD; i++) step_chk("t4r_restart_dead", 6'b00_00_00);
      step_chk("t4r_restart_on", 6'b10_10_10);

      // randomized tail: monitors check overlap and dead gaps on all phases
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk);
         #1;
         if ($urandom_range(0, 9) == 0) pwm_a = ~pwm_a;
         if ($urandom_range(0, 7) == 0) pwm_b = ~pwm_b;
         if ($urandom_range(0, 11) == 0) pwm_c = ~pwm_c;
         if ($urandom_range(0, 99) == 0) en = ~en;
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
         end
      end
      en = 1'b1;
      repeat (2) @(posedge clk);
      done = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
